aux_stream_bridge: RTL and testbench

//  Multi-channel bridge between the risc16f84 aux bus and AXI-stream byte channels, generalising the

---
 rtl/aux_stream_bridge.sv | 250 +++++++++++++++++++++++++
 tb/tb_aux_stream_bridge.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_stream_bridge.sv
// aux_stream_bridge
//   Multi-channel bridge between the risc16f84 aux bus and AXI-stream byte
//   channels. Each of NUM_CH channels owns a TX FIFO (CPU -> m_axis), an RX
//   FIFO (s_axis -> CPU), sticky overflow flags and two interrupt enables.
//   Channel c decodes at BASE_ADDR+4c .. BASE_ADDR+4c+3:
//     +0 DATA   write pushes TX, read returns/pops RX head
//     +1 STATUS {3'b0, RXOVF, TXOVF, rx_full, rx_empty, tx_empty}
//     +2 CTRL   write: b0 tx_flush, b1 rx_flush, b2 clear OVF, b3 rx_ie, b4 tx_ie
//               read : {3'b0, tx_ie, rx_ie, 3'b0}
//     +3 RXCNT  RX occupancy, saturating at 8'hFF
//
// Ports
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   aux_adr_i/aux_dat_i  aux address and write data
//   aux_dat_o            combinational read data (0 when not decoded)
//   aux_we_i/aux_re_i    write/read strobes, acted on only in their first cycle
//   aux_hit_o            address decodes to this block
//   m_tdata/m_tvalid/m_tready  per-channel TX stream (channel c at [c*W +: W])
//   s_tdata/s_tvalid/s_tready  per-channel RX stream
//   irq_o                registered interrupt request
module aux_stream_bridge #(
  parameter int NUM_CH         = 2,
  parameter int FIFO_AW        = 4,
  parameter int AUX_ADDR_WIDTH = 16,
  parameter int AUX_DATA_WIDTH = 8,
  parameter logic [AUX_ADDR_WIDTH-1:0] BASE_ADDR = 16'hFF00
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [AUX_ADDR_WIDTH-1:0]        aux_adr_i,
  input  logic [AUX_DATA_WIDTH-1:0]        aux_dat_i,
  output logic [AUX_DATA_WIDTH-1:0]        aux_dat_o,
  input  logic                             aux_we_i,
  input  logic                             aux_re_i,
  output logic                             aux_hit_o,
  output logic [NUM_CH*AUX_DATA_WIDTH-1:0] m_tdata,
  output logic [NUM_CH-1:0]                m_tvalid,
  input  logic [NUM_CH-1:0]                m_tready,
  input  logic [NUM_CH*AUX_DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]                s_tvalid,
  output logic [NUM_CH-1:0]                s_tready,
  output logic                             irq_o
);

  localparam int W     = AUX_DATA_WIDTH;
  localparam int AW    = AUX_ADDR_WIDTH;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  // Address decode. The subtraction is one bit wider than the address so
  // that addresses below BASE_ADDR show up as negative (MSB set) instead of
  // wrapping into the channel window.
  logic [AW:0]   offset;
  logic          inRange;
  logic [AW-3:0] chIdx;
  logic [1:0]    regSel;

  assign offset    = {1'b0, aux_adr_i} - {1'b0, BASE_ADDR};
  assign inRange   = !offset[AW] && (offset < (AW+1)'(4 * NUM_CH));
  assign chIdx     = offset[AW-1:2];
  assign regSel    = offset[1:0];
  assign aux_hit_o = inRange;

  // Strobe history: an access acts only in the first cycle of a strobe, so a
  // CPU holding a strobe for several cycles still pushes or pops once. A
  // write wins over a simultaneous read, and that read has no side effect.
  logic weHist_q, reHist_q;
  logic weAct, reAct;

  assign weAct = aux_we_i & ~weHist_q;
  assign reAct = aux_re_i & ~reHist_q & ~aux_we_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      weHist_q <= 1'b0;
      reHist_q <= 1'b0;
    end else begin
      weHist_q <= aux_we_i;
      reHist_q <= aux_re_i;
    end
  end

  logic [NUM_CH-1:0]   chSelV;
  logic [NUM_CH-1:0]   irqSrc;
  logic [NUM_CH*W-1:0] chRdFlat;

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    logic         chSel;
    logic [W-1:0] txMem [DEPTH];
    logic [W-1:0] rxMem [DEPTH];

    logic [PW-1:0] txWr_q, txWr_d, txRd_q, txRd_d;
    logic [PW-1:0] rxWr_q, rxWr_d, rxRd_q, rxRd_d;
    logic          txOvf_q, txOvf_d, rxOvf_q, rxOvf_d;
    logic          txIe_q, txIe_d, rxIe_q, rxIe_d;

    logic txEmpty, txFull, rxEmpty, rxFull;
    logic dataWr, dataRd, ctrlWr;
    logic txPush, txPop, rxPush, rxPop;
    logic txFlush, rxFlush, ovfClr, txOvfSet, rxOvfSet;
    logic [PW-1:0] rxCnt;
    logic [7:0]    rxCntByte;
    logic [W-1:0]  rdData;

    assign chSel = inRange && (chIdx == (AW-2)'(c));

    // Pointers carry a wrap bit: equal pointers mean empty, equal low bits
    // with differing wrap bits mean full.
    assign txEmpty = (txWr_q == txRd_q);
    assign txFull  = (txWr_q[FIFO_AW] != txRd_q[FIFO_AW]) &&
                     (txWr_q[FIFO_AW-1:0] == txRd_q[FIFO_AW-1:0]);
    assign rxEmpty = (rxWr_q == rxRd_q);
    assign rxFull  = (rxWr_q[FIFO_AW] != rxRd_q[FIFO_AW]) &&
                     (rxWr_q[FIFO_AW-1:0] == rxRd_q[FIFO_AW-1:0]);

    assign dataWr = weAct & chSel & (regSel == 2'd0);
    assign ctrlWr = weAct & chSel & (regSel == 2'd2);
    assign dataRd = reAct & chSel & (regSel == 2'd0);

    // Fullness is judged on the state before the edge, so a CPU write into a
    // full TX FIFO is dropped even if the stream side drains a byte this cycle.
    assign txPush   = dataWr & ~txFull;
    assign txOvfSet = dataWr & txFull;
    assign txPop    = ~txEmpty & m_tready[c];
    assign rxPush   = s_tvalid[c] & ~rxFull;
    assign rxOvfSet = s_tvalid[c] & rxFull;
    assign rxPop    = dataRd & ~rxEmpty;

    assign txFlush = ctrlWr & aux_dat_i[0];
    assign rxFlush = ctrlWr & aux_dat_i[1];
    assign ovfClr  = ctrlWr & aux_dat_i[2];

    // Next-state for pointers, flags and enables. A flush overrides any
    // push/pop in the same cycle; a fresh overflow wins over a clear so an
    // event arriving with the clear is not lost.
    always_comb begin
      txWr_d  = txWr_q;
      txRd_d  = txRd_q;
      rxWr_d  = rxWr_q;
      rxRd_d  = rxRd_q;
      txOvf_d = txOvf_q;
      rxOvf_d = rxOvf_q;
      txIe_d  = txIe_q;
      rxIe_d  = rxIe_q;

      if (txFlush) begin
        txWr_d = '0;
        txRd_d = '0;
      end else begin
        if (txPush) txWr_d = txWr_q + PW'(1);
        if (txPop)  txRd_d = txRd_q + PW'(1);
      end

      if (rxFlush) begin
        rxWr_d = '0;
        rxRd_d = '0;
      end else begin
        if (rxPush) rxWr_d = rxWr_q + PW'(1);
        if (rxPop)  rxRd_d = rxRd_q + PW'(1);
      end

      if (ovfClr) begin
        txOvf_d = 1'b0;
        rxOvf_d = 1'b0;
      end
      if (txOvfSet) txOvf_d = 1'b1;
      if (rxOvfSet) rxOvf_d = 1'b1;

      if (ctrlWr) begin
        rxIe_d = aux_dat_i[3];
        txIe_d = aux_dat_i[4];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        txWr_q  <= '0;
        txRd_q  <= '0;
        rxWr_q  <= '0;
        rxRd_q  <= '0;
        txOvf_q <= 1'b0;
        rxOvf_q <= 1'b0;
        txIe_q  <= 1'b0;
        rxIe_q  <= 1'b0;
      end else begin
        txWr_q  <= txWr_d;
        txRd_q  <= txRd_d;
        rxWr_q  <= rxWr_d;
        rxRd_q  <= rxRd_d;
        txOvf_q <= txOvf_d;
        rxOvf_q <= rxOvf_d;
        txIe_q  <= txIe_d;
        rxIe_q  <= rxIe_d;
      end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
      if (txPush) txMem[txWr_q[FIFO_AW-1:0]] <= aux_dat_i;
      if (rxPush) rxMem[rxWr_q[FIFO_AW-1:0]] <= s_tdata[c*W +: W];
    end

    assign m_tvalid[c]        = ~txEmpty;
    assign m_tdata[c*W +: W]  = txMem[txRd_q[FIFO_AW-1:0]];
    assign s_tready[c]        = ~rxFull;

    assign rxCnt = rxWr_q - rxRd_q;

    always_comb begin
      rxCntByte = 8'(rxCnt);
      if (32'(rxCnt) > 255) rxCntByte = 8'hFF;
    end

    always_comb begin
      rdData = '0;
      case (regSel)
        2'd0:    rdData = rxEmpty ? '0 : rxMem[rxRd_q[FIFO_AW-1:0]];
        2'd1:    rdData = W'({rxOvf_q, txOvf_q, rxFull, rxEmpty, txEmpty});
        2'd2:    rdData = W'({txIe_q, rxIe_q, 3'b000});
        default: rdData = W'(rxCntByte);
      endcase
    end

    assign chSelV[c]           = chSel;
    assign chRdFlat[c*W +: W]  = rdData;
    assign irqSrc[c]           = (rxIe_q & ~rxEmpty) | (txIe_q & txEmpty);
  end

  // Read mux: at most one channel is selected; unmapped addresses read 0.
  always_comb begin
    aux_dat_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chSelV[i]) aux_dat_o = chRdFlat[i*W +: W];
    end
  end

  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |irqSrc;
  end

  assign irq_o = irq_q;

  // Upper CTRL data bits carry no function.
  logic unusedDatBits;
  assign unusedDatBits = ^aux_dat_i[W-1:5];

endmodule

// File: tb/tb_aux_stream_bridge.sv
// tb_aux_stream_bridge
//   Directed self-checking bench for aux_stream_bridge with two channels,
//   16-deep FIFOs and the register window at 16'hFF00.
module tb_aux_stream_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] aux_adr_i = '0;
  logic [7:0]  aux_dat_i = '0;
  logic [7:0]  aux_dat_o;
  logic        aux_we_i = 1'b0;
  logic        aux_re_i = 1'b0;
  logic        aux_hit_o;
  logic [15:0] m_tdata;
  logic [1:0]  m_tvalid;
  logic [1:0]  m_tready = '0;
  logic [15:0] s_tdata = '0;
  logic [1:0]  s_tvalid = '0;
  logic [1:0]  s_tready;
  logic        irq_o;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] txBeats [$];

  aux_stream_bridge #(
    .NUM_CH(2), .FIFO_AW(4), .AUX_ADDR_WIDTH(16), .AUX_DATA_WIDTH(8), .BASE_ADDR(16'hFF00)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .aux_adr_i(aux_adr_i), .aux_dat_i(aux_dat_i), .aux_dat_o(aux_dat_o),
    .aux_we_i(aux_we_i), .aux_re_i(aux_re_i), .aux_hit_o(aux_hit_o),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Collect every accepted channel-0 TX beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && m_tvalid[0] && m_tready[0]) txBeats.push_back(m_tdata[7:0]);
  end

  // Single-cycle write strobe.
  task automatic auxWrite(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    aux_adr_i = addr;
    aux_dat_i = data;
    aux_we_i  = 1'b1;
    @(posedge clk); #1;
    aux_we_i  = 1'b0;
  endtask

  // Single-cycle read strobe; data and hit sampled before the acting edge.
  task automatic auxRead(input logic [15:0] addr, output logic [7:0] data, output logic hit);
    @(posedge clk); #1;
    aux_adr_i = addr;
    aux_re_i  = 1'b1;
    @(negedge clk);
    data = aux_dat_o;
    hit  = aux_hit_o;
    @(posedge clk); #1;
    aux_re_i  = 1'b0;
  endtask

  // One-beat RX transfer (caller guarantees s_tready is high).
  task automatic pushRx(input int ch, input logic [7:0] data);
    @(posedge clk); #1;
    s_tdata[ch*8 +: 8] = data;
    s_tvalid[ch] = 1'b1;
    @(posedge clk); #1;
    s_tvalid[ch] = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic hit;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (m_tvalid !== 2'b00 || s_tready !== 2'b11 || irq_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got tvalid=%b tready=%b irq=%b expected 00 11 0", m_tvalid, s_tready, irq_o);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    auxRead(16'hFF01, rd, hit);
    testsRun++;
    if (rd !== 8'h03 || hit !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_status0: got %h hit=%b expected 03 hit=1", rd, hit);
    end
    auxRead(16'hFF05, rd, hit);
    testsRun++;
    if (rd !== 8'h03) begin
      testsFailed++;
      $display("[TB] FAIL reset_status1: got %h expected 03", rd);
    end
    auxRead(16'hFF03, rd, hit);
    testsRun++;
    if (rd !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset_rxcnt0: got %h expected 00", rd);
    end
    auxRead(16'hFF08, rd, hit);
    testsRun++;
    if (rd !== 8'h00 || hit !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL unmapped_above: got %h hit=%b expected 00 hit=0", rd, hit);
    end
    auxRead(16'hFEFF, rd, hit);
    testsRun++;
    if (rd !== 8'h00 || hit !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL unmapped_below: got %h hit=%b expected 00 hit=0", rd, hit);
    end
  endtask

  task automatic test_held_strobe();
    @(posedge clk); #1;
    m_tready = 2'b01;
    txBeats.delete();
    aux_adr_i = 16'hFF00;
    aux_dat_i = 8'hA5;
    aux_we_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    aux_we_i  = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (txBeats.size() !== 1) begin
      testsFailed++;
      $display("[TB] FAIL held_strobe_beats: got %0d beats expected 1", txBeats.size());
    end
    testsRun++;
    if (txBeats.size() == 0 || txBeats[0] !== 8'hA5) begin
      testsFailed++;
      $display("[TB] FAIL held_strobe_data: got %h expected a5", (txBeats.size() == 0) ? 8'h00 : txBeats[0]);
    end
    testsRun++;
    if (m_tvalid[0] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL held_strobe_idle: got tvalid=%b expected 0", m_tvalid[0]);
    end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] rd;
    logic hit;
    int badOrder;
    @(posedge clk); #1;
    m_tready = 2'b00;
    for (int i = 0; i < 17; i++) auxWrite(16'hFF00, 8'(i));
    @(negedge clk);
    testsRun++;
    if (m_tvalid[0] !== 1'b1 || m_tdata[7:0] !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL tx_head_hold: got tvalid=%b tdata=%h expected 1 00", m_tvalid[0], m_tdata[7:0]);
    end
    auxRead(16'hFF01, rd, hit);
    testsRun++;
    if (rd !== 8'h0A) begin
      testsFailed++;
      $display("[TB] FAIL tx_ovf_status: got %h expected 0a", rd);
    end
    txBeats.delete();
    @(posedge clk); #1;
    m_tready = 2'b01;
    repeat (20) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (txBeats.size() !== 16) begin
      testsFailed++;
      $display("[TB] FAIL tx_drain_count: got %0d beats expected 16", txBeats.size());
    end
    badOrder = 0;
    for (int i = 0; i < txBeats.size(); i++) if (txBeats[i] !== 8'(i)) badOrder++;
    testsRun++;
    if (badOrder != 0) begin
      testsFailed++;
      $display("[TB] FAIL tx_drain_order: got %0d out-of-order beats expected 0", badOrder);
    end
    auxRead(16'hFF01, rd, hit);
    testsRun++;
    if (rd !== 8'h0B) begin
      testsFailed++;
      $display("[TB] FAIL tx_drained_status: got %h expected 0b", rd);
    end
    auxWrite(16'hFF02, 8'h04);
    auxRead(16'hFF01, rd, hit);
    testsRun++;
    if (rd !== 8'h03) begin
      testsFailed++;
      $display("[TB] FAIL ovf_clear_status: got %h expected 03", rd);
    end
  endtask

  task automatic test_rx_path();
    logic [7:0] rd;
    logic hit;
    logic [7:0] expBytes [3];
    expBytes[0] = 8'h11;
    expBytes[1] = 8'h22;
    expBytes[2] = 8'h33;
    for (int i = 0; i < 3; i++) pushRx(1, expBytes[i]);
    auxRead(16'hFF07, rd, hit);
    testsRun++;
    if (rd !== 8'h03) begin
      testsFailed++;
      $display("[TB] FAIL rx_count1: got %h expected 03", rd);
    end
    auxRead(16'hFF03, rd, hit);
    testsRun++;
    if (rd !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL rx_count0_isolated: got %h expected 00", rd);
    end
    for (int i = 0; i < 3; i++) begin
      auxRead(16'hFF04, rd, hit);
      testsRun++;
      if (rd !== expBytes[i]) begin
        testsFailed++;
        $display("[TB] FAIL rx_data_%0d: got %h expected %h", i, rd, expBytes[i]);
      end
    end
    auxRead(16'hFF04, rd, hit);
    testsRun++;
    if (rd !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL rx_empty_read: got %h expected 00", rd);
    end
    auxRead(16'hFF07, rd, hit);
    testsRun++;
    if (rd !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL rx_count_after_empty: got %h expected 00", rd);
    end
  endtask

  task automatic test_irq();
    logic [7:0] rd;
    logic hit;
    auxWrite(16'hFF02, 8'h08);
    auxRead(16'hFF02, rd, hit);
    testsRun++;
    if (rd !== 8'h08) begin
      testsFailed++;
      $display("[TB] FAIL ctrl_readback: got %h expected 08", rd);
    end
    @(negedge clk);
    testsRun++;
    if (irq_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL irq_idle: got %b expected 0", irq_o);
    end
    pushRx(0, 8'h5C);
    @(negedge clk);
    testsRun++;
    if (irq_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL irq_latency: got %b expected 0 in push cycle", irq_o);
    end
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (irq_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL irq_rx_assert: got %b expected 1", irq_o);
    end
    auxRead(16'hFF00, rd, hit);
    testsRun++;
    if (rd !== 8'h5C) begin
      testsFailed++;
      $display("[TB] FAIL irq_pop_data: got %h expected 5c", rd);
    end
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (irq_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL irq_rx_deassert: got %b expected 0", irq_o);
    end
    auxWrite(16'hFF02, 8'h10);
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (irq_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL irq_tx_empty: got %b expected 1", irq_o);
    end
    auxWrite(16'hFF02, 8'h00);
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (irq_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL irq_disabled: got %b expected 0", irq_o);
    end
  endtask

  task automatic test_rx_flush();
    logic [7:0] rd;
    logic hit;
    for (int i = 0; i < 16; i++) pushRx(0, 8'h40 + 8'(i));
    @(negedge clk);
    testsRun++;
    if (s_tready[0] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rx_full_ready: got %b expected 0", s_tready[0]);
    end
    auxRead(16'hFF03, rd, hit);
    testsRun++;
    if (rd !== 8'h10) begin
      testsFailed++;
      $display("[TB] FAIL rx_full_count: got %h expected 10", rd);
    end
    auxRead(16'hFF01, rd, hit);
    testsRun++;
    if (rd !== 8'h05) begin
      testsFailed++;
      $display("[TB] FAIL rx_full_status: got %h expected 05", rd);
    end
    // Flush in the same cycle as an offered (blocked) beat.
    @(posedge clk); #1;
    aux_adr_i = 16'hFF02;
    aux_dat_i = 8'h02;
    aux_we_i  = 1'b1;
    s_tdata[7:0] = 8'h99;
    s_tvalid[0]  = 1'b1;
    @(posedge clk); #1;
    aux_we_i    = 1'b0;
    s_tvalid[0] = 1'b0;
    @(negedge clk);
    testsRun++;
    if (s_tready[0] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL flush_ready: got %b expected 1", s_tready[0]);
    end
    auxRead(16'hFF03, rd, hit);
    testsRun++;
    if (rd !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL flush_count: got %h expected 00", rd);
    end
    auxRead(16'hFF01, rd, hit);
    testsRun++;
    if (rd !== 8'h13) begin
      testsFailed++;
      $display("[TB] FAIL flush_status: got %h expected 13", rd);
    end
    pushRx(0, 8'h61);
    pushRx(0, 8'h62);
    auxRead(16'hFF00, rd, hit);
    testsRun++;
    if (rd !== 8'h61) begin
      testsFailed++;
      $display("[TB] FAIL resume_first: got %h expected 61", rd);
    end
    auxRead(16'hFF00, rd, hit);
    testsRun++;
    if (rd !== 8'h62) begin
      testsFailed++;
      $display("[TB] FAIL resume_second: got %h expected 62", rd);
    end
  endtask

  initial begin
    test_reset();
    test_held_strobe();
    test_tx_overflow();
    test_rx_path();
    test_irq();
    test_rx_flush();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog: the sequence is a fixed number of cycles, so this only fires
  // if something stalls the scheduler.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
